// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the Memory-stage access controller.
// Contents:
//   - default widths and wait timeout
//   - state_t : controller FSM encoding (3 bits)
//   - req_malformed() : decides whether a new request is a protocol error
package mem_stage_ctrl_pkg;

    localparam int ADDR_W_DEFAULT  = 16;
    localparam int DATA_W_DEFAULT  = 16;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // A request is malformed when the address is not word aligned or when
    // it asks for a load and a store at the same time.
    function automatic logic req_malformed(input logic addr_lsb,
                                           input logic rd,
                                           input logic wr);
        return addr_lsb | (rd & wr);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_wait_counter.sv
// Timeout counter for the WAIT phase of a memory access.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       synchronous clear (has priority over enable)
//   enable      count one cycle
//   terminal    count has reached LIMIT
// The counter saturates at LIMIT so it can never wrap back to zero.
module mem_stage_ctrl_wait_counter #(
    parameter int LIMIT = 15,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    assign terminal = (count == CNT_W'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle data-memory front end for the Memory pipeline stage.
// Takes one load or store from the Execute->Memory register, issues it to a
// variable-latency memory, and returns load data to Memory->Writeback.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_addr, req_wdata   access address / store data
//   req_rd, req_wr        load / store request
//   halt                  blocks new requests (in-flight access still finishes)
//   stall                 hold upstream pipe registers this cycle
//   rdata, rdata_valid    load data (held) / one-cycle completion pulse
//   err                   sticky protocol error, cleared only by reset
//   mem_addr, mem_wdata   latched access address / write data to memory
//   mem_rd, mem_wr        one-cycle memory strobes
//   mem_busy              memory cannot take a strobe this cycle
//   mem_done, mem_rdata   one-cycle completion pulse with its read data
//   dbg_state             current controller state
//
// Handshakes: upstream offers a request by holding req_rd/req_wr; it is taken
// in IDLE, and stall tells upstream to hold until the completion cycle
// (rdata_valid), where stall drops and upstream advances. Toward memory, a
// strobe is only raised in a cycle where mem_busy is low, so every strobe is
// accepted by memory the cycle it is seen; mem_done is only honoured in WAIT.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              halt,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_t            dbg_state
);

    state_t            state;
    state_t            state_nxt;
    logic              new_req;
    logic              bad_req;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              op_rd_q;
    logic              cnt_clear;
    logic              cnt_en;
    logic              cnt_tc;

    assign new_req = (req_rd | req_wr) & ~halt;
    assign bad_req = req_malformed(req_addr[0], req_rd, req_wr);

    mem_stage_ctrl_wait_counter #(
        .LIMIT (TIMEOUT)
    ) u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (cnt_tc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (new_req) begin
                    state_nxt = bad_req ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mem_busy) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion arriving on the last allowed cycle still counts.
                if (mem_done) begin
                    state_nxt = ST_RESP;
                end else if (cnt_tc) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall       = 1'b0;
        rdata_valid = 1'b0;
        err         = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        case (state)
            ST_IDLE: stall = new_req;
            ST_ISSUE: begin
                stall = 1'b1;
                if (!mem_busy) begin
                    mem_rd    = op_rd_q;
                    mem_wr    = ~op_rd_q;
                    cnt_clear = 1'b1;
                end
            end
            ST_WAIT: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
            end
            ST_RESP: rdata_valid = 1'b1;
            ST_ERR:  err = 1'b1;
            default: ;
        endcase
    end

    // Request latch and load-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_rd_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == ST_IDLE && new_req && !bad_req) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                op_rd_q <= req_rd;
            end
            if (state == ST_WAIT && mem_done && op_rd_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed accesses, a memory
// responder, a cycle-level reference model checked every cycle, and a queue
// of hand-computed completion data.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_rd = 1'b0;
    logic          req_wr = 1'b0;
    logic          halt = 1'b0;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_busy = 1'b0;
    logic          mem_done;
    logic [DW-1:0] mem_rdata = '0;
    state_t        dbg_state;

    logic resp_done = 1'b0;
    logic inject_done = 1'b0;
    int   done_delay = 1;
    assign mem_done = resp_done | inject_done;

    mem_stage_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .halt        (halt),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [DW-1:0] exp_q[$];
    int n_rd = 0, n_wr = 0, n_stall = 0, n_valid = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- memory responder ----------------
    // done_delay = N raises mem_done N cycles after the strobe cycle; 0 = never.
    initial begin
        int cd;
        cd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) cd = 0;
            else if ((mem_rd || mem_wr) && done_delay > 0) cd = done_delay;
            @(posedge clk);
            #1;
            resp_done = (cd == 1);
            if (cd > 0) cd--;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    initial begin
        bit            m_err, m_job, m_strobed, m_resp, m_is_rd, nreq, idle;
        int            waited;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rdata, qv;
        bit            e_stall, e_rd, e_wr;
        m_err = 0; m_job = 0; m_strobed = 0; m_resp = 0; m_is_rd = 0; waited = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_err = 0; m_job = 0; m_strobed = 0; m_resp = 0; waited = 0;
                m_addr = '0; m_wdata = '0; m_rdata = '0;
                check("rst_stall", 32'(stall), 32'd0);
                check("rst_valid", 32'(rdata_valid), 32'd0);
                check("rst_err", 32'(err), 32'd0);
                check("rst_mem_rd", 32'(mem_rd), 32'd0);
                check("rst_mem_wr", 32'(mem_wr), 32'd0);
                check("rst_rdata", 32'(rdata), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'd0);
                check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            end else begin
                nreq = (req_rd || req_wr) && !halt;
                idle = !m_err && !m_job && !m_resp;
                e_stall = idle ? nreq : (m_job && !m_err);
                e_rd = m_job && !m_strobed && !mem_busy && m_is_rd;
                e_wr = m_job && !m_strobed && !mem_busy && !m_is_rd;
                check("stall", 32'(stall), 32'(e_stall));
                check("rdata_valid", 32'(rdata_valid), 32'(m_resp));
                check("err", 32'(err), 32'(m_err));
                check("mem_rd", 32'(mem_rd), 32'(e_rd));
                check("mem_wr", 32'(mem_wr), 32'(e_wr));
                check("rdata", 32'(rdata), 32'(m_rdata));
                check("mem_addr", 32'(mem_addr), 32'(m_addr));
                check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                if (rdata_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        qv = exp_q.pop_front();
                        check("completion_rdata", 32'(rdata), 32'(qv));
                    end
                end
                n_rd    += int'(mem_rd);
                n_wr    += int'(mem_wr);
                n_stall += int'(stall);
                n_valid += int'(rdata_valid);
                // advance the model by one clock
                if (m_resp) begin
                    m_resp = 0;
                end else if (m_err) begin
                    // sticky: nothing moves
                end else if (idle && nreq) begin
                    if (req_addr[0] || (req_rd && req_wr)) begin
                        m_err = 1;
                    end else begin
                        m_job = 1; m_strobed = 0; m_is_rd = req_rd;
                        m_addr = req_addr; m_wdata = req_wdata;
                    end
                end else if (m_job && !m_strobed) begin
                    if (!mem_busy) begin
                        m_strobed = 1;
                        waited = 0;
                    end
                end else if (m_job) begin
                    if (mem_done) begin
                        m_job = 0;
                        m_resp = 1;
                        if (m_is_rd) m_rdata = mem_rdata;
                    end else begin
                        waited++;
                        if (waited > TO) begin
                            m_err = 1;
                            m_job = 0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
        step();
        req_rd = 0; req_wr = 0;
    endtask

    // Steps until a completion or error is visible, bounded by budget cycles.
    task automatic wait_end(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (rdata_valid || err) break;
            step();
        end
        check({name, "_seen"}, 32'(rdata_valid || err), 32'd1);
    endtask

    task automatic do_reset();
        req_rd = 0; req_wr = 0; halt = 0; mem_busy = 0; inject_done = 0;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int s_rd, s_wr, s_st, s_va;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
        check("lit_reset_stall", 32'(stall), 32'd0);
        check("lit_reset_err", 32'(err), 32'd0);
        check("lit_reset_rdata", 32'(rdata), 32'd0);

        // Load 0x0010 -> 0xBEEF at minimum latency.
        s_rd = n_rd; s_st = n_stall; s_va = n_valid;
        done_delay = 1; mem_rdata = 16'hBEEF; exp_q.push_back(16'hBEEF);
        issue(1, 0, 16'h0010, 16'h0000);
        wait_end("load1", 10);
        check("lit_load1_rdata", 32'(rdata), 32'h0000BEEF);
        step();
        check("lit_load1_rd_pulses", 32'(n_rd - s_rd), 32'd1);
        check("lit_load1_stall_cycles", 32'(n_stall - s_st), 32'd3);
        check("lit_load1_valid_pulses", 32'(n_valid - s_va), 32'd1);

        // Store 0x0020 <= 0x1234 with memory busy for 3 cycles.
        s_rd = n_rd; s_wr = n_wr; s_st = n_stall;
        done_delay = 2; mem_rdata = 16'h5555; exp_q.push_back(16'hBEEF);
        mem_busy = 1;
        issue(0, 1, 16'h0020, 16'h1234);
        check("lit_store_no_wr_busy", 32'(mem_wr), 32'd0);
        step();
        check("lit_store_no_wr_busy2", 32'(mem_wr), 32'd0);
        step();
        mem_busy = 0;
        #1;
        check("lit_store_wr", 32'(mem_wr), 32'd1);
        check("lit_store_addr", 32'(mem_addr), 32'h0020);
        check("lit_store_wdata", 32'(mem_wdata), 32'h1234);
        wait_end("store", 10);
        step();
        check("lit_store_wr_pulses", 32'(n_wr - s_wr), 32'd1);
        check("lit_store_rd_pulses", 32'(n_rd - s_rd), 32'd0);
        check("lit_store_stall_cycles", 32'(n_stall - s_st), 32'd6);
        check("lit_store_rdata_kept", 32'(rdata), 32'h0000BEEF);

        // Load with a longer latency.
        done_delay = 3; mem_rdata = 16'h5A5A; exp_q.push_back(16'h5A5A);
        issue(1, 0, 16'h00A4, 16'hFFFF);
        wait_end("load2", 10);
        step();
        check("lit_load2_rdata", 32'(rdata), 32'h00005A5A);

        // halt in IDLE blocks the request.
        s_rd = n_rd;
        halt = 1; req_rd = 1; req_addr = 16'h0040;
        #1;
        check("lit_halt_stall", 32'(stall), 32'd0);
        step();
        step();
        req_rd = 0; halt = 0;
        step();
        check("lit_halt_no_strobe", 32'(n_rd - s_rd), 32'd0);

        // halt rising while waiting: access still completes.
        s_va = n_valid;
        done_delay = 4; mem_rdata = 16'hC0DE; exp_q.push_back(16'hC0DE);
        issue(1, 0, 16'h0044, 16'h0000);
        step();
        halt = 1;
        wait_end("halt_wait", 10);
        step();
        halt = 0;
        check("lit_halt_wait_valid", 32'(n_valid - s_va), 32'd1);
        check("lit_halt_wait_rdata", 32'(rdata), 32'h0000C0DE);

        // Completion on the last allowed waiting cycle wins over timeout.
        done_delay = TO + 1; mem_rdata = 16'h0F0F; exp_q.push_back(16'h0F0F);
        issue(1, 0, 16'h0046, 16'h0000);
        wait_end("edge_done", 30);
        check("lit_edge_no_err", 32'(err), 32'd0);
        check("lit_edge_valid", 32'(rdata_valid), 32'd1);
        step();

        // Reset in the middle of a wait.
        done_delay = 0;
        issue(1, 0, 16'h0060, 16'h0000);
        step();
        step();
        rst_n = 0;
        #1;
        check("lit_midrst_stall", 32'(stall), 32'd0);
        check("lit_midrst_rdata", 32'(rdata), 32'd0);
        check("lit_midrst_addr", 32'(mem_addr), 32'd0);
        check("lit_midrst_rd", 32'(mem_rd), 32'd0);
        step();
        rst_n = 1;
        step();
        done_delay = 2; mem_rdata = 16'h7777; exp_q.push_back(16'h7777);
        issue(1, 0, 16'h0062, 16'h0000);
        wait_end("after_rst", 10);
        check("lit_after_rst_rdata", 32'(rdata), 32'h00007777);
        step();

        // Timeout: no completion ever.
        s_va = n_valid;
        done_delay = 0;
        issue(1, 0, 16'h0050, 16'h0000);
        wait_end("timeout", 40);
        check("lit_timeout_err", 32'(err), 32'd1);
        check("lit_timeout_stall", 32'(stall), 32'd0);
        inject_done = 1;
        step();
        inject_done = 0;
        step();
        check("lit_late_done_err", 32'(err), 32'd1);
        check("lit_late_done_no_valid", 32'(n_valid - s_va), 32'd0);
        check("lit_timeout_rdata_frozen", 32'(rdata), 32'h00007777);

        // Odd address.
        do_reset();
        s_rd = n_rd;
        done_delay = 1;
        issue(1, 0, 16'h0011, 16'h0000);
        check("lit_odd_err", 32'(err), 32'd1);
        check("lit_odd_stall", 32'(stall), 32'd0);
        step();
        step();
        check("lit_odd_no_rd", 32'(n_rd - s_rd), 32'd0);

        // Load and store together.
        do_reset();
        issue(1, 1, 16'h0030, 16'h0000);
        check("lit_rdwr_err", 32'(err), 32'd1);
        step();
        check("lit_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
